// File: rtl/pkt_pair_dispatch.sv
// Ingress header FIFO that feeds two classifier lanes. Headers leave in pairs
// whenever two are buffered. A lone header leaves on lane 1 after a timeout or on flush.
module pkt_pair_dispatch #(
  parameter int PACKET_WIDTH  = 104,
  parameter int FIFO_DEPTH    = 8,
  parameter int FLUSH_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          RSTn,
  input  logic [PACKET_WIDTH-1:0]       pkt_in,
  input  logic                          pkt_in_valid,
  output logic                          pkt_in_ready,
  input  logic                          flush,
  output logic [PACKET_WIDTH-1:0]       packet_out1,
  output logic [PACKET_WIDTH-1:0]       packet_out2,
  output logic                          pkt_valid_out1,
  output logic                          pkt_valid_out2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   disp_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [7:0]    WAIT_MAX = 8'(FLUSH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    DISP_NONE,
    DISP_SINGLE,
    DISP_PAIR
  } disp_e;

  logic [PACKET_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [7:0]              r_wait_cnt;
  logic [PACKET_WIDTH-1:0] r_out1;
  logic [PACKET_WIDTH-1:0] r_out2;
  logic                    r_vld1;
  logic                    r_vld2;
  logic [31:0]             r_disp_cnt;

  disp_e                   w_disp;
  logic                    w_push;
  logic [1:0]              w_pop_n;
  logic [AW-1:0]           w_rd_ptr_p1;

  // Readiness looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign pkt_in_ready = (r_count < DEPTH_C);
  assign w_push       = pkt_in_valid & pkt_in_ready;
  assign w_rd_ptr_p1  = r_rd_ptr + AW'(1);

  // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
  always_comb begin
    w_disp  = DISP_NONE;
    w_pop_n = 2'd0;
    if (r_count >= CW'(2)) begin
      w_disp  = DISP_PAIR;
      w_pop_n = 2'd2;
    end else if (r_count == CW'(1) && (r_wait_cnt == WAIT_MAX || flush)) begin
      w_disp  = DISP_SINGLE;
      w_pop_n = 2'd1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pkt_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wait_cnt <= '0;
      r_disp_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr   <= r_rd_ptr + AW'(w_pop_n);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop_n);
      r_disp_cnt <= r_disp_cnt + 32'(w_pop_n);
      if (r_count == CW'(1) && w_disp == DISP_NONE) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // Lane outputs are zeroed whenever their valid is low.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_out1 <= '0;
      r_out2 <= '0;
      r_vld1 <= 1'b0;
      r_vld2 <= 1'b0;
    end else begin
      case (w_disp)
        DISP_PAIR: begin
          r_out1 <= r_mem[r_rd_ptr];
          r_out2 <= r_mem[w_rd_ptr_p1];
          r_vld1 <= 1'b1;
          r_vld2 <= 1'b1;
        end
        DISP_SINGLE: begin
          r_out1 <= r_mem[r_rd_ptr];
          r_out2 <= '0;
          r_vld1 <= 1'b1;
          r_vld2 <= 1'b0;
        end
        default: begin
          r_out1 <= '0;
          r_out2 <= '0;
          r_vld1 <= 1'b0;
          r_vld2 <= 1'b0;
        end
      endcase
    end
  end

  assign packet_out1    = r_out1;
  assign packet_out2    = r_out2;
  assign pkt_valid_out1 = r_vld1;
  assign pkt_valid_out2 = r_vld2;
  assign fifo_count     = r_count;
  assign disp_cnt       = r_disp_cnt;

endmodule

// File: tb/tb_pkt_pair_dispatch.sv
// Directed bench for pkt_pair_dispatch. It covers pairing, timeout, flush, a streamed
// run across pointer wrap, the odd tail, and asynchronous reset in mid-stream.
module tb_pkt_pair_dispatch;

  localparam int W  = 104;
  localparam int D  = 8;
  localparam int T  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          RSTn;
  logic [W-1:0]  pkt_in;
  logic          pkt_in_valid;
  logic          pkt_in_ready;
  logic          flush;
  logic [W-1:0]  packet_out1;
  logic [W-1:0]  packet_out2;
  logic          pkt_valid_out1;
  logic          pkt_valid_out2;
  logic [CW-1:0] fifo_count;
  logic [31:0]   disp_cnt;

  int n_vec = 0;
  int n_err = 0;

  pkt_pair_dispatch #(
    .PACKET_WIDTH (W),
    .FIFO_DEPTH   (D),
    .FLUSH_TIMEOUT(T)
  ) dut (
    .clk           (clk),
    .RSTn          (RSTn),
    .pkt_in        (pkt_in),
    .pkt_in_valid  (pkt_in_valid),
    .pkt_in_ready  (pkt_in_ready),
    .flush         (flush),
    .packet_out1   (packet_out1),
    .packet_out2   (packet_out2),
    .pkt_valid_out1(pkt_valid_out1),
    .pkt_valid_out2(pkt_valid_out2),
    .fifo_count    (fifo_count),
    .disp_cnt      (disp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input logic [W-1:0] h);
    pkt_in       = h;
    pkt_in_valid = 1'b1;
    tick();
    pkt_in_valid = 1'b0;
    pkt_in       = '0;
  endtask

  // Called right after the edge that left exactly one header buffered with wait_cnt at 0.
  task automatic expect_timeout_single(input string tag, input logic [W-1:0] h);
    for (int i = 0; i < T - 1; i++) begin
      tick();
      chk({tag, "_wait_v1"}, pkt_valid_out1, 1'b0);
    end
    tick();
    chk({tag, "_v1"},   pkt_valid_out1, 1'b1);
    chk({tag, "_out1"}, packet_out1, h);
    chk({tag, "_v2"},   pkt_valid_out2, 1'b0);
    chk({tag, "_out2"}, packet_out2, '0);
  endtask

  function automatic logic [W-1:0] hdr(input int tag_id);
    return {8'hC5, 64'h0123_4567_89AB_CDEF, 32'(tag_id)};
  endfunction

  logic [W-1:0] got_q[$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTn         = 1'b0;
    pkt_in       = '0;
    pkt_in_valid = 1'b0;
    flush        = 1'b0;
    #12;
    chk("rst_ready", pkt_in_ready, 1'b1);
    chk("rst_count", fifo_count, '0);
    chk("rst_v1",    pkt_valid_out1, 1'b0);
    chk("rst_v2",    pkt_valid_out2, 1'b0);
    chk("rst_disp",  disp_cnt, '0);
    @(negedge clk);
    RSTn = 1'b1;
    tick();

    // Back-to-back pairing: A,B,C,D on consecutive edges.
    push_hdr(hdr(16'hA));
    chk("b2b_e1_v1",    pkt_valid_out1, 1'b0);
    chk("b2b_e1_count", fifo_count, CW'(1));
    push_hdr(hdr(16'hB));
    chk("b2b_e2_v1",    pkt_valid_out1, 1'b0);
    chk("b2b_e2_count", fifo_count, CW'(2));
    push_hdr(hdr(16'hC));
    chk("b2b_e3_v1",    pkt_valid_out1, 1'b1);
    chk("b2b_e3_v2",    pkt_valid_out2, 1'b1);
    chk("b2b_e3_out1",  packet_out1, hdr(16'hA));
    chk("b2b_e3_out2",  packet_out2, hdr(16'hB));
    chk("b2b_e3_count", fifo_count, CW'(1));
    push_hdr(hdr(16'hD));
    chk("b2b_e4_v1",    pkt_valid_out1, 1'b0);
    chk("b2b_e4_out1",  packet_out1, '0);
    chk("b2b_e4_count", fifo_count, CW'(2));
    tick();
    chk("b2b_e5_v1",    pkt_valid_out1, 1'b1);
    chk("b2b_e5_v2",    pkt_valid_out2, 1'b1);
    chk("b2b_e5_out1",  packet_out1, hdr(16'hC));
    chk("b2b_e5_out2",  packet_out2, hdr(16'hD));
    chk("b2b_e5_count", fifo_count, '0);
    chk("b2b_disp",     disp_cnt, 32'd4);

    // Lone header leaves after the timeout.
    push_hdr(hdr(16'h10));
    chk("to_count", fifo_count, CW'(1));
    expect_timeout_single("to", hdr(16'h10));
    chk("to_disp",  disp_cnt, 32'd5);
    chk("to_empty", fifo_count, '0);

    // Flush one cycle after acceptance, then flush with an empty FIFO.
    push_hdr(hdr(16'h20));
    flush = 1'b1;
    tick();
    chk("fl_v1",   pkt_valid_out1, 1'b1);
    chk("fl_out1", packet_out1, hdr(16'h20));
    chk("fl_v2",   pkt_valid_out2, 1'b0);
    chk("fl_disp", disp_cnt, 32'd6);
    tick();
    chk("fl_empty_v1", pkt_valid_out1, 1'b0);
    chk("fl_empty_disp", disp_cnt, 32'd6);
    flush = 1'b0;

    // Partial wait, then flush; the next lone header must wait the full timeout again.
    push_hdr(hdr(16'h21));
    tick();
    chk("flw_v1", pkt_valid_out1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flw_out1", packet_out1, hdr(16'h21));
    chk("flw_v1b",  pkt_valid_out1, 1'b1);
    push_hdr(hdr(16'h22));
    expect_timeout_single("flw_to", hdr(16'h22));
    chk("flw_disp", disp_cnt, 32'd8);

    // Nine headers streamed at one per cycle; pointers wrap during this run.
    got_q.delete();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("st_ready%0d", i), pkt_in_ready, 1'b1);
      push_hdr(hdr(16'h100 + i));
      if (pkt_valid_out1) got_q.push_back(packet_out1);
      if (pkt_valid_out2) got_q.push_back(packet_out2);
      chk($sformatf("st_v2v1_%0d", i), pkt_valid_out2 & ~pkt_valid_out1, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pkt_valid_out1) got_q.push_back(packet_out1);
      if (pkt_valid_out2) got_q.push_back(packet_out2);
    end
    chk("st_len", got_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("st_ord%0d", i), (i < got_q.size()) ? got_q[i] : '0, hdr(16'h100 + i));
    end
    chk("st_disp",  disp_cnt, 32'd17);
    chk("st_count", fifo_count, '0);

    // Odd tail: a pair, then a single after timeout; flush while two are buffered changes nothing.
    push_hdr(hdr(16'h30));
    push_hdr(hdr(16'h31));
    flush = 1'b1;
    push_hdr(hdr(16'h32));
    flush = 1'b0;
    chk("tail_v1",   pkt_valid_out1, 1'b1);
    chk("tail_v2",   pkt_valid_out2, 1'b1);
    chk("tail_out1", packet_out1, hdr(16'h30));
    chk("tail_out2", packet_out2, hdr(16'h31));
    expect_timeout_single("tail", hdr(16'h32));
    chk("tail_disp", disp_cnt, 32'd20);

    // Asynchronous reset while lanes are valid and one header is still buffered.
    push_hdr(hdr(16'h40));
    push_hdr(hdr(16'h41));
    push_hdr(hdr(16'h42));
    chk("mr_pre_v1", pkt_valid_out1, 1'b1);
    #2;
    RSTn = 1'b0;
    #1;
    chk("mr_v1",    pkt_valid_out1, 1'b0);
    chk("mr_v2",    pkt_valid_out2, 1'b0);
    chk("mr_out1",  packet_out1, '0);
    chk("mr_out2",  packet_out2, '0);
    chk("mr_count", fifo_count, '0);
    chk("mr_ready", pkt_in_ready, 1'b1);
    chk("mr_disp",  disp_cnt, '0);
    @(negedge clk);
    RSTn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("mr_idle%0d", i), pkt_valid_out1, 1'b0);
    end
    push_hdr(hdr(16'h50));
    chk("mr_post_count", fifo_count, CW'(1));
    expect_timeout_single("mr_post", hdr(16'h50));
    chk("mr_post_disp", disp_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
